// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory writer.
//   MEM_BYTES_DEF : default byte capacity of the target instruction memory
//   BYTE_W        : width of one memory write lane
//   state_e       : session FSM states
//   addr_oob()    : true when a word at the given byte address would not fit
package imem_pkg;

  localparam int MEM_BYTES_DEF = 1000;
  localparam int BYTE_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  // lim is the highest byte address at which a whole 4-byte word still fits.
  function automatic logic addr_oob(input logic [31:0] a, input logic [31:0] lim);
    return a > lim;
  endfunction

endpackage

// File: rtl/imem_byte_sel.sv
// Big-endian byte lane select: index 0 returns the most significant byte.
//   word_i : 32-bit instruction word
//   idx_i  : byte index 0..3 (0 = lowest memory address)
//   byte_o : selected byte
module imem_byte_sel
  import imem_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [1:0]        idx_i,
  output logic [BYTE_W-1:0] byte_o
);

  always_comb begin
    byte_o = word_i[31:24];
    case (idx_i)
      2'd0: byte_o = word_i[31:24];
      2'd1: byte_o = word_i[23:16];
      2'd2: byte_o = word_i[15:8];
      2'd3: byte_o = word_i[7:0];
      default: byte_o = word_i[31:24];
    endcase
  end

endmodule

// File: rtl/imem_writer.sv
// Instruction memory loader: accepts 32-bit words one at a time and writes
// each as four big-endian bytes on consecutive cycles, starting at base_addr.
//   clk, rst_n          : clock, async active-low reset
//   start, base_addr    : begin a session (accepted in IDLE or ERR only)
//   word_valid/data/last: incoming word stream, word_ready handshake
//   mem_we/addr/wdata   : byte write port to instruction memory
//   busy, done, err     : session status (done = 1-cycle pulse, err sticky)
//   word_count          : words completely written this session (saturating)
module imem_writer
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  // Highest legal word base address; anything above would spill past MEM_BYTES.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] word_q,  word_d;
  logic        last_q,  last_d;
  logic [1:0]  idx_q,   idx_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        err_q,   err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          cnt_d  = '0;
          addr_d = base_addr;
          idx_d  = '0;
          if (base_addr[1:0] != 2'b00 || addr_oob(base_addr, LAST_WORD)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT_WORD;
            err_d   = 1'b0;
          end
        end
      end
      ST_WAIT_WORD: begin
        if (word_valid) begin
          word_d  = word_data;
          last_d  = word_last;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = 2'(idx_q + 2'd1);
        if (idx_q == 2'd3) begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : 16'(cnt_q + 16'd1);
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 32'd4;
            // Check the next word's base before asking for it.
            if (addr_oob(addr_q + 32'd4, LAST_WORD)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = ST_WAIT_WORD;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  imem_byte_sel u_sel (
    .word_i (word_q),
    .idx_i  (idx_q),
    .byte_o (mem_wdata)
  );

  // All outputs decode from reset registers, so reset clears them immediately.
  assign word_ready = (state_q == ST_WAIT_WORD);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = addr_q + {30'b0, idx_q};
  assign busy       = (state_q == ST_WAIT_WORD) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_writer.sv
// Scoreboard bench for imem_writer: sessions push expected byte writes into a
// queue computed from the word list; a negedge monitor pops and compares.
module tb_imem_writer;

  localparam int          MEMB = 1000;
  localparam logic [31:0] LIM  = 32'd996;

  logic        clk, rst_n, start, word_valid, word_last;
  logic [31:0] base_addr, word_data;
  logic        word_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] word_count;

  imem_writer #(.MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] words_a [16];
  int          n_cmp = 0, n_bad = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (word_ready) chk("ready_only_in_wait", {30'b0, mem_we, busy}, 32'd1);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", {24'b0, mem_wdata}, {24'b0, e.d});
        end
        chk("wr_below_capacity", 32'(mem_addr < MEMB), 32'd1);
      end
    end
  end

  // One load session of n words from words_a (last flag on word n-1).
  task automatic run_session(input logic [31:0] base, input int n, input int gap, input bit poke);
    int acc = 0, t, d0;
    bit e = 0, d = 0;
    logic [31:0] a = base;
    // Reference: words land at base, base+4, ... until last or the next base no longer fits.
    if (base[1:0] != 0 || base > LIM) e = 1;
    else begin
      for (int i = 0; i < n; i++) begin
        acc++;
        for (int k = 0; k < 4; k++)
          exp_q.push_back('{a: a + 32'(k), d: 8'(words_a[i] >> (24 - 8 * k))});
        if (i == n - 1) begin d = 1; break; end
        a = a + 32'd4;
        if (a > LIM) begin e = 1; break; end
      end
    end
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom;
    @(negedge clk);
    chk("err_after_start", 32'(e && acc == 0), {31'b0, err});
    for (int i = 0; i < acc; i++) begin
      repeat (gap) begin @(negedge clk); word_data = $urandom; end
      t = 0;
      while (!word_ready && t < 100) begin @(negedge clk); word_data = $urandom; t++; end
      chk("ready_timeout", 32'(t < 100), 32'd1);
      word_valid = 1'b1; word_data = words_a[i]; word_last = (i == n - 1);
      @(posedge clk); #1;
      word_valid = 1'b0; word_last = 1'b0; word_data = $urandom;
      if (poke) begin
        @(negedge clk);
        start = 1'b1; base_addr = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == d0 && !err && t < 100) begin @(negedge clk); #1; t++; end
    repeat (2) @(negedge clk);
    #1;
    chk("end_timeout",   32'(t < 100), 32'd1);
    chk("done_pulses",   32'(done_cnt - d0), 32'(d));
    chk("err_end",       {31'b0, err}, 32'(e));
    chk("busy_end",      {31'b0, busy}, 32'd0);
    chk("word_count",    {16'b0, word_count}, 32'(acc));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (e) chk("ready_in_err", {31'b0, word_ready | mem_we}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    word_valid = 1'b0; word_data = '0; word_last = 1'b0;
    #1;
    chk("rst_ctrl", {27'b0, word_ready, mem_we, busy, done, err}, 32'd0);
    chk("rst_addr_data", mem_addr | {24'b0, mem_wdata}, 32'd0);
    chk("rst_count", {16'b0, word_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    words_a[0] = 32'h8C010004;
    run_session(32'd0, 1, 0, 0);
    words_a[0] = 32'h1; words_a[1] = 32'h2; words_a[2] = 32'h3;
    run_session(32'd8, 3, 3, 0);
    run_session(32'd6, 1, 0, 0);
    words_a[0] = 32'hDEADBEEF;
    run_session(32'd0, 1, 1, 0);
    words_a[0] = 32'h11223344; words_a[1] = 32'h55667788;
    run_session(32'd992, 2, 0, 0);
    words_a[2] = 32'h99AABBCC;
    run_session(32'd992, 3, 0, 0);
    words_a[0] = 32'hCAFEF00D; words_a[1] = 32'h0BADC0DE;
    run_session(32'd100, 2, 1, 1);
    run_session(32'd1000, 1, 0, 0);

    // Reset while byte index 2 is on the bus; the rest of the word is abandoned.
    words_a[0] = 32'hA1B2C3D4;
    exp_q.push_back('{a: 32'h20, d: 8'hA1});
    exp_q.push_back('{a: 32'h21, d: 8'hB2});
    exp_q.push_back('{a: 32'h22, d: 8'hC3});
    @(negedge clk);
    start = 1'b1; base_addr = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    word_valid = 1'b1; word_data = words_a[0]; word_last = 1'b1;
    begin
      int t = 0;
      while (!(mem_we && mem_addr == 32'h22) && t < 50) begin @(negedge clk); #1; t++; end
      chk("reset_mid_write_reached", 32'(t < 50), 32'd1);
    end
    word_valid = 1'b0; word_last = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'b0, word_ready, mem_we, busy, done, err}, 32'd0);
    chk("async_rst_addr_data", mem_addr | {24'b0, mem_wdata}, 32'd0);
    chk("async_rst_count", {16'b0, word_count}, 32'd0);
    chk("async_rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    words_a[0] = 32'h01020304;
    run_session(32'd40, 1, 0, 0);

    for (int s = 0; s < 12; s++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 249)) * 32'd4;
        1: b = 32'd968 + 32'($urandom_range(0, 7)) * 32'd4;
        2: b = 32'($urandom_range(0, 248)) * 32'd4 + 32'($urandom_range(1, 3));
        default: b = 32'd1000 + 32'($urandom_range(0, 5000));
      endcase
      for (int i = 0; i < 16; i++) words_a[i] = $urandom;
      run_session(b, $urandom_range(1, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
